// File: rtl/display_scheduler.sv
`timescale 1ns/1ps
// display_scheduler
// Shares a 4-digit seven-segment display between two periodic sources
// (rotated on a dwell timer) and a pre-emptive, blinking alert that holds
// for a fixed time before handing the display back.
//
// state | meaning
// IDLE  | no source enabled, display shows dashes
// SHOW0 | src0 on display for one dwell period
// SHOW1 | src1 on display for one dwell period
// ALERT | latched alert word on display, blinking, for the hold time
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES  = 150_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] src0_bcd,
  input  logic        src0_en,
  input  logic [15:0] src1_bcd,
  input  logic        src1_en,
  input  logic        alert_req,
  input  logic [15:0] alert_bcd,
  output logic        alert_ack,
  output logic [15:0] bcd_out,
  output logic [1:0]  active_src,
  output logic        alert_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2,
    ALERT = 2'd3
  } state_t;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
  localparam logic [15:0] DASHES     = 16'hFFFF;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] blink_q, blink_d;
  logic        phase_q, phase_d;
  logic [15:0] word_q, word_d;
  logic        ack_d;
  logic [15:0] bcd_d;
  logic [1:0]  src_d;
  logic        busy_d;

  // State register plus the counters, return slot and latched alert word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      word_q  <= DASHES;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      word_q  <= word_d;
    end
  end

  // Next-state: alert pre-empts everything, then hold expiry, source loss,
  // dwell rotation, and finally leaving IDLE.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q + 32'd1;
    word_d  = word_q;
    ack_d   = 1'b0;
    if (alert_req) begin
      state_d = ALERT;
      cnt_d   = '0;
      word_d  = alert_bcd;
      ack_d   = 1'b1;
      // A retrigger must not overwrite the source we will return to.
      if (state_q != ALERT) ret_d = state_q;
    end else begin
      case (state_q)
        ALERT: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (ret_q == SHOW0 && src0_en)      state_d = SHOW0;
            else if (ret_q == SHOW1 && src1_en) state_d = SHOW1;
            else if (src0_en)                   state_d = SHOW0;
            else if (src1_en)                   state_d = SHOW1;
            else                                state_d = IDLE;
          end
        end
        SHOW0: begin
          if (!src0_en) begin
            state_d = src1_en ? SHOW1 : IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (src1_en) state_d = SHOW1;
          end
        end
        SHOW1: begin
          if (!src1_en) begin
            state_d = src0_en ? SHOW0 : IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (src0_en) state_d = SHOW0;
          end
        end
        IDLE: begin
          if (src0_en) begin
            state_d = SHOW0;
            cnt_d   = '0;
          end else if (src1_en) begin
            state_d = SHOW1;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timing: restarts in the visible phase on every accepted alert.
  always_comb begin
    blink_d = '0;
    phase_d = 1'b1;
    if (!alert_req && state_q == ALERT) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 32'd1;
        phase_d = phase_q;
      end
    end
  end

  // Output selection from the current state; registered below.
  always_comb begin
    bcd_d  = DASHES;
    src_d  = 2'd3;
    busy_d = 1'b0;
    case (state_q)
      SHOW0: begin
        bcd_d = src0_bcd;
        src_d = 2'd0;
      end
      SHOW1: begin
        bcd_d = src1_bcd;
        src_d = 2'd1;
      end
      ALERT: begin
        bcd_d  = phase_q ? word_q : DASHES;
        src_d  = 2'd2;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers, one cycle behind the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= DASHES;
      active_src <= 2'd3;
      alert_busy <= 1'b0;
      alert_ack  <= 1'b0;
    end else begin
      bcd_out    <= bcd_d;
      active_src <= src_d;
      alert_busy <= busy_d;
      alert_ack  <= ack_d;
    end
  end

endmodule
